// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// R0_HARDWIRED_EN makes register 0 a constant zero (never forwarded).
package hazard_pkg;

  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_EXEC = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_WB   = 2'd3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MWAIT   = 2'd1,
    TIMEOUT = 2'd2
  } haz_state_t;

  // Producer matches a consumer address; r0 never matches when hardwired.
  function automatic logic prod_hit(
    input logic        valid,
    input logic [31:0] dest,
    input logic [31:0] src
  );
`ifdef R0_HARDWIRED_EN
    return valid && (dest == src) && (src != 32'd0);
`else
    return valid && (dest == src);
`endif
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand bypass select: one source against E/M/W producers.
// R0_HARDWIRED_EN (via hazard_pkg) suppresses matches on register 0.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REGBITS = 4,
  parameter int MUXBITS = 2
) (
  input  logic [REGBITS-1:0] src,
  input  logic [REGBITS-1:0] dest_e,
  input  logic [REGBITS-1:0] dest_m,
  input  logic [REGBITS-1:0] dest_w,
  input  logic               valid_e,
  input  logic               valid_m,
  input  logic               valid_w,
  output logic [MUXBITS-1:0] sel,
  output logic               hit_e
);

  logic hit_m;
  logic hit_w;

  assign hit_e = prod_hit(valid_e, 32'(dest_e), 32'(src));
  assign hit_m = prod_hit(valid_m, 32'(dest_m), 32'(src));
  assign hit_w = prod_hit(valid_w, 32'(dest_w), 32'(src));

  // Youngest producer wins.
  always_comb begin
    sel = MUXBITS'(SEL_REG);
    priority case (1'b1)
      hit_e:   sel = MUXBITS'(SEL_EXEC);
      hit_m:   sel = MUXBITS'(SEL_MEM);
      hit_w:   sel = MUXBITS'(SEL_WB);
      default: sel = MUXBITS'(SEL_REG);
    endcase
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: bypass selects, load-use, memory wait FSM.
// R0_HARDWIRED_EN treats register 0 as constant zero.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REGBITS  = 4,
  parameter int MUXBITS  = 2,
  parameter int NSRC     = 2,
  parameter int WAITBITS = 4,
  parameter int CNTBITS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC*REGBITS-1:0] src_D,
  input  logic [REGBITS-1:0]      dest_E,
  input  logic [REGBITS-1:0]      dest_M,
  input  logic [REGBITS-1:0]      dest_W,
  input  logic                    wrt_en_E,
  input  logic                    wrt_en_M,
  input  logic                    wrt_en_W,
  input  logic                    noop_E,
  input  logic                    noop_M,
  input  logic                    noop_W,
  input  logic                    is_load_E,
  input  logic                    is_load_M,
  input  logic                    mem_ready_M,
  output logic [NSRC*MUXBITS-1:0] src_sel_D,
  output logic                    stall_D,
  output logic                    bubble_E,
  output logic                    stall_all,
  output logic [1:0]              haz_state,
  output logic                    mem_timeout,
  output logic [CNTBITS-1:0]      stall_cycles
);

  localparam logic [WAITBITS-1:0] WAIT_LAST = ~WAITBITS'(1);

  logic                valid_e;
  logic                valid_m;
  logic                valid_w;
  logic [NSRC-1:0]     hit_e;
  logic                load_use;
  logic                mem_wait;
  haz_state_t          state;
  logic [WAITBITS-1:0] wait_cnt;

  assign valid_e = wrt_en_E & ~noop_E;
  assign valid_m = wrt_en_M & ~noop_M;
  assign valid_w = wrt_en_W & ~noop_W;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_select #(
      .REGBITS(REGBITS),
      .MUXBITS(MUXBITS)
    ) u_sel (
      .src    (src_D[s*REGBITS +: REGBITS]),
      .dest_e (dest_E),
      .dest_m (dest_M),
      .dest_w (dest_W),
      .valid_e(valid_e),
      .valid_m(valid_m),
      .valid_w(valid_w),
      .sel    (src_sel_D[s*MUXBITS +: MUXBITS]),
      .hit_e  (hit_e[s])
    );
  end

  assign load_use  = is_load_E & (|hit_e);
  assign mem_wait  = is_load_M & valid_M_q() & ~mem_ready_M;
  assign stall_all = mem_wait;
  assign stall_D   = load_use | mem_wait;
  assign bubble_E  = load_use & ~mem_wait;
  assign haz_state = state;

  function automatic logic valid_M_q();
    return valid_m;
  endfunction

  // Memory-wait FSM; wait_cnt counts registered wait cycles incl. the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MWAIT;
            wait_cnt <= WAITBITS'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        MWAIT: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt == WAIT_LAST) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TIMEOUT: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of decode stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_D && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit.
// Honours R0_HARDWIRED_EN to choose the register-0 expectations.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src_D;
  logic [3:0] dest_E, dest_M, dest_W;
  logic       wrt_en_E, wrt_en_M, wrt_en_W;
  logic       noop_E, noop_M, noop_W;
  logic       is_load_E, is_load_M, mem_ready_M;
  logic [3:0] src_sel_D;
  logic       stall_D, bubble_E, stall_all;
  logic [1:0] haz_state;
  logic       mem_timeout;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  hazard_forward_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_D       (src_D),
    .dest_E      (dest_E),
    .dest_M      (dest_M),
    .dest_W      (dest_W),
    .wrt_en_E    (wrt_en_E),
    .wrt_en_M    (wrt_en_M),
    .wrt_en_W    (wrt_en_W),
    .noop_E      (noop_E),
    .noop_M      (noop_M),
    .noop_W      (noop_W),
    .is_load_E   (is_load_E),
    .is_load_M   (is_load_M),
    .mem_ready_M (mem_ready_M),
    .src_sel_D   (src_sel_D),
    .stall_D     (stall_D),
    .bubble_E    (bubble_E),
    .stall_all   (stall_all),
    .haz_state   (haz_state),
    .mem_timeout (mem_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %0h required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk_comb(input string t, input logic [3:0] sel,
                          input logic sd, input logic bub,
                          input logic sa);
    push({t, "_sel"}, 32'(sel));
    push({t, "_stallD"}, 32'(sd));
    push({t, "_bubble"}, 32'(bub));
    push({t, "_stallall"}, 32'(sa));
    #1;
    pop_chk(32'(src_sel_D));
    pop_chk(32'(stall_D));
    pop_chk(32'(bubble_E));
    pop_chk(32'(stall_all));
  endtask

  task automatic chk_reg(input string t, input logic [1:0] st,
                         input logic to, input logic [15:0] cyc);
    push({t, "_state"}, 32'(st));
    push({t, "_timeout"}, 32'(to));
    push({t, "_cycles"}, 32'(cyc));
    pop_chk(32'(haz_state));
    pop_chk(32'(mem_timeout));
    pop_chk(32'(stall_cycles));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    src_D = '0;
    {dest_E, dest_M, dest_W} = '0;
    {wrt_en_E, wrt_en_M, wrt_en_W} = '0;
    {noop_E, noop_M, noop_W} = '0;
    {is_load_E, is_load_M} = '0;
    mem_ready_M = 1'b1;
    #1;
    chk_reg("reset", 2'd0, 1'b0, 16'd0);
    #1 rst_n = 1'b1;
    tick();

    // No dependencies
    src_D = {4'd5, 4'd4};
    dest_E = 4'd7; dest_M = 4'd9; dest_W = 4'd2;
    {wrt_en_E, wrt_en_M, wrt_en_W} = 3'b111;
    chk_comb("nodep", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Priority: op1 from E, op0 from M over W
    dest_E = 4'd5; dest_M = 4'd4; dest_W = 4'd4;
    chk_comb("prio", 4'b0110, 1'b0, 1'b0, 1'b0);

    // E is a bubble: op0 falls through to W
    noop_E = 1'b1;
    dest_E = 4'd4; dest_M = 4'd0; dest_W = 4'd4;
    chk_comb("noopE", 4'b0011, 1'b0, 1'b0, 1'b0);
    tick();
    chk_reg("nostall", 2'd0, 1'b0, 16'd0);

    // Load-use: one bubble
    noop_E = 1'b0; is_load_E = 1'b1;
    wrt_en_M = 1'b0; wrt_en_W = 1'b0;
    chk_comb("lduse", 4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk_reg("lduse", 2'd0, 1'b0, 16'd1);

    // Load now in M with data ready
    noop_E = 1'b1; is_load_E = 1'b0; wrt_en_E = 1'b0;
    dest_M = 4'd4; wrt_en_M = 1'b1; is_load_M = 1'b1;
    mem_ready_M = 1'b1;
    chk_comb("ldmem", 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    chk_reg("ldmem", 2'd0, 1'b0, 16'd1);

    // Memory wait coinciding with a load-use in E
    mem_ready_M = 1'b0;
    noop_E = 1'b0; wrt_en_E = 1'b1; is_load_E = 1'b1;
    dest_E = 4'd5;
    chk_comb("bothhaz", 4'b0110, 1'b1, 1'b0, 1'b1);
    noop_E = 1'b1; wrt_en_E = 1'b0; is_load_E = 1'b0;
    chk_comb("mwait", 4'b0010, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_reg("mwait", 2'd1, 1'b0, 16'(1 + i));
    end
    mem_ready_M = 1'b1;
    chk_comb("mdone", 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    chk_reg("mdone", 2'd0, 1'b0, 16'd4);

    // Watchdog timeout after 15 wait edges
    mem_ready_M = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 14) chk_reg("wait14", 2'd1, 1'b0, 16'd18);
    end
    chk_reg("timeout", 2'd2, 1'b1, 16'd19);
    mem_ready_M = 1'b1;
    tick();
    chk_reg("torun", 2'd0, 1'b1, 16'd19);

    // Asynchronous reset mid-wait
    mem_ready_M = 1'b0;
    tick();
    tick();
    chk_reg("wait2", 2'd1, 1'b1, 16'd21);
    rst_n = 1'b0;
    #1;
    chk_reg("asyncrst", 2'd0, 1'b0, 16'd0);
    chk_comb("rstcomb", 4'b0010, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    mem_ready_M = 1'b1;
    is_load_M = 1'b0; wrt_en_M = 1'b0;
    tick();

    // Register-0 load in E against operand 0 == r0
    src_D = {4'd5, 4'd0};
    dest_E = 4'd0; wrt_en_E = 1'b1; noop_E = 1'b0;
    is_load_E = 1'b1;
`ifdef R0_HARDWIRED_EN
    chk_comb("r0", 4'b0000, 1'b0, 1'b0, 1'b0);
`else
    chk_comb("r0", 4'b0001, 1'b1, 1'b1, 1'b0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

endmodule
